// File: rtl/exec_mem_unit.sv
// Purpose: EX/MEM datapath: ALU-control decode, 32-bit ALU with zero flag, byte-addressable data memory.
// Latency: ALU and memory read are combinational (0 cycles); memory write/clear commit on the rising clk edge.
// Backpressure: none; every input is accepted every cycle and there is no stall path.
//
// Ports:
//   clk, reset            clock and synchronous active-high reset (clears data memory only)
//   alu_op, funct         control-unit class and R-type function field -> alu_ctrl
//   op1, op2, shamt       ALU operands and immediate shift amount
//   alu_ctrl, alu_result, zero_flag   decoded operation, result, result==0
//   mem_addr, mem_wdata   byte address and store data (address taken from EX/MEM, not the ALU)
//   mem_ctrl, word_byte   00/11 idle, 01 read, 10 write; 0 word, 1 byte
//   mem_rdata             load data (byte loads sign-extended)
module exec_mem_unit #(
    parameter int MEM_BYTES = 1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [2:0]  alu_op,
    input  logic [5:0]  funct,
    input  logic [31:0] op1,
    input  logic [31:0] op2,
    input  logic [4:0]  shamt,
    output logic [3:0]  alu_ctrl,
    output logic [31:0] alu_result,
    output logic        zero_flag,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic [1:0]  mem_ctrl,
    input  logic        word_byte,
    output logic [31:0] mem_rdata
);

    localparam int AW = $clog2(MEM_BYTES);

    localparam logic [3:0] CTRL_AND  = 4'b0000;
    localparam logic [3:0] CTRL_OR   = 4'b0001;
    localparam logic [3:0] CTRL_ADD  = 4'b0010;
    localparam logic [3:0] CTRL_XOR  = 4'b0011;
    localparam logic [3:0] CTRL_NOR  = 4'b0100;
    localparam logic [3:0] CTRL_SLTU = 4'b0101;
    localparam logic [3:0] CTRL_SUB  = 4'b0110;
    localparam logic [3:0] CTRL_SLT  = 4'b0111;
    localparam logic [3:0] CTRL_SLL  = 4'b1000;
    localparam logic [3:0] CTRL_SRL  = 4'b1001;
    localparam logic [3:0] CTRL_SRA  = 4'b1010;
    localparam logic [3:0] CTRL_SLLV = 4'b1011;
    localparam logic [3:0] CTRL_SRLV = 4'b1100;

    localparam logic [1:0] MEM_READ  = 2'b01;
    localparam logic [1:0] MEM_WRITE = 2'b10;

    // ------------------------------------------------------------------
    // ALU-control decode
    // ------------------------------------------------------------------
    logic [3:0] funct_ctrl;

    always_comb begin
        funct_ctrl = CTRL_ADD;  // jr and any unlisted funct fall back to ADD
        case (funct)
            6'b100000, 6'b100001: funct_ctrl = CTRL_ADD;
            6'b100010, 6'b100011: funct_ctrl = CTRL_SUB;
            6'b100100:            funct_ctrl = CTRL_AND;
            6'b100101:            funct_ctrl = CTRL_OR;
            6'b100110:            funct_ctrl = CTRL_XOR;
            6'b100111:            funct_ctrl = CTRL_NOR;
            6'b101010:            funct_ctrl = CTRL_SLT;
            6'b101011:            funct_ctrl = CTRL_SLTU;
            6'b000000:            funct_ctrl = CTRL_SLL;
            6'b000010:            funct_ctrl = CTRL_SRL;
            6'b000011:            funct_ctrl = CTRL_SRA;
            6'b000100:            funct_ctrl = CTRL_SLLV;
            6'b000110:            funct_ctrl = CTRL_SRLV;
            6'b001000:            funct_ctrl = CTRL_ADD;
            default:              funct_ctrl = CTRL_ADD;
        endcase
    end

    always_comb begin
        alu_ctrl = CTRL_ADD;
        case (alu_op)
            3'b000:  alu_ctrl = CTRL_ADD;
            3'b001:  alu_ctrl = CTRL_SUB;
            3'b010:  alu_ctrl = funct_ctrl;
            3'b011:  alu_ctrl = CTRL_AND;
            3'b100:  alu_ctrl = CTRL_OR;
            3'b101:  alu_ctrl = CTRL_XOR;
            3'b110:  alu_ctrl = CTRL_SLT;
            3'b111:  alu_ctrl = CTRL_SLTU;
            default: alu_ctrl = CTRL_ADD;
        endcase
    end

    // ------------------------------------------------------------------
    // ALU (not reset; purely a function of its operands)
    // ------------------------------------------------------------------
    always_comb begin
        alu_result = 32'h0;
        case (alu_ctrl)
            CTRL_AND:  alu_result = op1 & op2;
            CTRL_OR:   alu_result = op1 | op2;
            CTRL_ADD:  alu_result = op1 + op2;
            CTRL_XOR:  alu_result = op1 ^ op2;
            CTRL_NOR:  alu_result = ~(op1 | op2);
            CTRL_SUB:  alu_result = op1 - op2;
            CTRL_SLT:  alu_result = {31'h0, $signed(op1) < $signed(op2)};
            CTRL_SLTU: alu_result = {31'h0, op1 < op2};
            CTRL_SLL:  alu_result = op2 << shamt;
            CTRL_SRL:  alu_result = op2 >> shamt;
            CTRL_SRA:  alu_result = $unsigned($signed(op2) >>> shamt);
            CTRL_SLLV: alu_result = op2 << op1[4:0];
            CTRL_SRLV: alu_result = op2 >> op1[4:0];
            default:   alu_result = 32'h0;
        endcase
    end

    assign zero_flag = (alu_result == 32'h0);

    // ------------------------------------------------------------------
    // Data memory: little-endian byte array; upper address bits wrap
    // ------------------------------------------------------------------
    logic [7:0]    mem [MEM_BYTES];
    logic [AW-1:0] byte_addr;
    logic [AW-1:0] word_addr0, word_addr1, word_addr2, word_addr3;

    assign byte_addr  = mem_addr[AW-1:0];
    // Word accesses align down by forcing the two low address bits.
    assign word_addr0 = {mem_addr[AW-1:2], 2'd0};
    assign word_addr1 = {mem_addr[AW-1:2], 2'd1};
    assign word_addr2 = {mem_addr[AW-1:2], 2'd2};
    assign word_addr3 = {mem_addr[AW-1:2], 2'd3};

    logic unused_addr_hi;
    assign unused_addr_hi = ^mem_addr[31:AW];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < MEM_BYTES; i++) begin
                mem[i[AW-1:0]] <= 8'h00;
            end
        end else if (mem_ctrl == MEM_WRITE) begin
            if (word_byte) begin
                mem[byte_addr] <= mem_wdata[7:0];
            end else begin
                mem[word_addr0] <= mem_wdata[7:0];
                mem[word_addr1] <= mem_wdata[15:8];
                mem[word_addr2] <= mem_wdata[23:16];
                mem[word_addr3] <= mem_wdata[31:24];
            end
        end
    end

    // Reads see the array as it stands before the edge, so a same-cycle
    // write to the same address is only visible afterwards.
    always_comb begin
        mem_rdata = 32'h0;
        if (!reset && mem_ctrl == MEM_READ) begin
            if (word_byte) begin
                mem_rdata = {{24{mem[byte_addr][7]}}, mem[byte_addr]};
            end else begin
                mem_rdata = {mem[word_addr3], mem[word_addr2], mem[word_addr1], mem[word_addr0]};
            end
        end
    end

endmodule

// File: tb/tb_exec_mem_unit.sv
// Purpose: directed self-checking bench for exec_mem_unit (ALU decode/arith and data memory).
// Latency: ALU/read checks sampled 1 time unit after inputs settle; writes commit on the posedge.
// Backpressure: not applicable; stimulus is a linear sequence of directed steps.
module tb_exec_mem_unit;

    logic        clk;
    logic        reset;
    logic [2:0]  alu_op;
    logic [5:0]  funct;
    logic [31:0] op1;
    logic [31:0] op2;
    logic [4:0]  shamt;
    logic [3:0]  alu_ctrl;
    logic [31:0] alu_result;
    logic        zero_flag;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [1:0]  mem_ctrl;
    logic        word_byte;
    logic [31:0] mem_rdata;

    int checks = 0;
    int errors = 0;

    exec_mem_unit #(.MEM_BYTES(1024)) dut (
        .clk        (clk),
        .reset      (reset),
        .alu_op     (alu_op),
        .funct      (funct),
        .op1        (op1),
        .op2        (op2),
        .shamt      (shamt),
        .alu_ctrl   (alu_ctrl),
        .alu_result (alu_result),
        .zero_flag  (zero_flag),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_ctrl   (mem_ctrl),
        .word_byte  (word_byte),
        .mem_rdata  (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic set_alu(input logic [2:0] op, input logic [5:0] fn,
                           input logic [31:0] a, input logic [31:0] b, input logic [4:0] sh);
        alu_op = op;
        funct  = fn;
        op1    = a;
        op2    = b;
        shamt  = sh;
        #1;
    endtask

    // Called at a negedge; holds the write across exactly one rising edge.
    task automatic mem_write(input logic [31:0] addr, input logic [31:0] data, input logic wb);
        mem_addr  = addr;
        mem_wdata = data;
        word_byte = wb;
        mem_ctrl  = 2'b10;
        @(negedge clk);
        mem_ctrl  = 2'b00;
    endtask

    task automatic mem_read_check(input string tag, input logic [31:0] addr, input logic wb,
                                  input logic [31:0] exp);
        mem_addr  = addr;
        word_byte = wb;
        mem_ctrl  = 2'b01;
        #1;
        check(tag, mem_rdata, exp);
        mem_ctrl  = 2'b00;
    endtask

    initial begin
        reset     = 1'b1;
        alu_op    = 3'b000;
        funct     = 6'b0;
        op1       = 32'h0;
        op2       = 32'h0;
        shamt     = 5'd0;
        mem_addr  = 32'h0;
        mem_wdata = 32'h0;
        mem_ctrl  = 2'b00;
        word_byte = 1'b0;

        repeat (2) @(negedge clk);

        // Read requested while reset is still high must return 0.
        mem_read_check("rdata_during_reset", 32'd8, 1'b0, 32'h0);
        reset = 1'b0;
        @(negedge clk);
        mem_read_check("rdata_after_reset", 32'd8, 1'b0, 32'h0);

        // ---------------- ALU ----------------
        set_alu(3'b010, 6'b100000, 32'd5, 32'd7, 5'd0);
        check("rtype_add_ctrl", {28'h0, alu_ctrl}, 32'h2);
        check("rtype_add_res", alu_result, 32'd12);
        check("rtype_add_zero", {31'h0, zero_flag}, 32'h0);

        set_alu(3'b001, 6'b000000, 32'h1234, 32'h1234, 5'd0);
        check("sub_ctrl", {28'h0, alu_ctrl}, 32'h6);
        check("sub_res", alu_result, 32'h0);
        check("sub_zero", {31'h0, zero_flag}, 32'h1);

        set_alu(3'b010, 6'b101010, 32'hFFFF_FFFF, 32'd1, 5'd0);
        check("slt_signed", alu_result, 32'h1);

        set_alu(3'b111, 6'b000000, 32'hFFFF_FFFF, 32'd1, 5'd0);
        check("sltu_unsigned", alu_result, 32'h0);

        set_alu(3'b010, 6'b000011, 32'h0, 32'h8000_0000, 5'd4);
        check("sra_ctrl", {28'h0, alu_ctrl}, 32'hA);
        check("sra_res", alu_result, 32'hF800_0000);

        set_alu(3'b010, 6'b000010, 32'h0, 32'h8000_0000, 5'd4);
        check("srl_res", alu_result, 32'h0800_0000);

        set_alu(3'b010, 6'b100111, 32'h0F0F_0F0F, 32'h00FF_00FF, 5'd0);
        check("nor_res", alu_result, 32'hF000_F000);

        // op1 = 36 -> shift amount from op1[4:0] = 4; shamt deliberately differs.
        set_alu(3'b010, 6'b000100, 32'd36, 32'd1, 5'd9);
        check("sllv_res", alu_result, 32'd16);

        set_alu(3'b010, 6'b111111, 32'd3, 32'd4, 5'd0);
        check("unknown_funct_ctrl", {28'h0, alu_ctrl}, 32'h2);
        check("unknown_funct_res", alu_result, 32'd7);

        set_alu(3'b101, 6'b000000, 32'h0000_00FF, 32'h0000_000F, 5'd0);
        check("xor_res", alu_result, 32'h0000_00F0);

        // ---------------- Memory ----------------
        @(negedge clk);
        mem_write(32'd8, 32'hDEAD_BEEF, 1'b0);
        mem_read_check("word_rd_8", 32'd8, 1'b0, 32'hDEAD_BEEF);
        mem_read_check("byte_rd_8", 32'd8, 1'b1, 32'hFFFF_FFEF);
        mem_read_check("byte_rd_11", 32'd11, 1'b1, 32'hFFFF_FFDE);

        // Idle encodings return 0 even with valid data at the address.
        mem_addr = 32'd8; word_byte = 1'b0; mem_ctrl = 2'b11; #1;
        check("idle11_rdata", mem_rdata, 32'h0);
        mem_ctrl = 2'b00; #1;
        check("idle00_rdata", mem_rdata, 32'h0);

        @(negedge clk);
        mem_write(32'd9, 32'h1234_567A, 1'b1);
        mem_read_check("word_rd_after_byte_wr", 32'd8, 1'b0, 32'hDEAD_7AEF);
        mem_read_check("byte_rd_9_positive", 32'd9, 1'b1, 32'h0000_007A);
        mem_read_check("word_rd_unaligned_10", 32'd10, 1'b0, 32'hDEAD_7AEF);
        mem_read_check("word_rd_wrap_1032", 32'd1032, 1'b0, 32'hDEAD_7AEF);

        // Write through a wrapped address lands at the low alias.
        @(negedge clk);
        mem_write(32'd1044, 32'hCAFE_F00D, 1'b0);
        mem_read_check("wrap_write_rd_20", 32'd20, 1'b0, 32'hCAFE_F00D);

        // One-cycle reset with a concurrent write: data cleared, write dropped.
        @(negedge clk);
        reset = 1'b1;
        mem_write(32'd16, 32'h5555_5555, 1'b0);
        reset = 1'b0;
        mem_read_check("rd_8_after_mid_reset", 32'd8, 1'b0, 32'h0);
        mem_read_check("rd_20_after_mid_reset", 32'd20, 1'b0, 32'h0);
        mem_read_check("rd_16_write_in_reset", 32'd16, 1'b0, 32'h0);

        // Memory still writable after reset.
        @(negedge clk);
        mem_write(32'd16, 32'h0BAD_CAFE, 1'b0);
        mem_read_check("rd_16_post_reset_wr", 32'd16, 1'b0, 32'h0BAD_CAFE);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
